// File: rtl/wb_gpio_ctrl.sv
// -----------------------------------------------------------------------------
// wb_gpio_ctrl
//
// Wishbone-classic slave that controls up to 32 GPIO pads and raises an
// interrupt on enabled rising/falling pad edges.
//
// Register map (word index = io_bus_ADR[4:2], all other address bits ignored):
//   0 OUT      RW    pad output data
//   1 OEB      RW    active-low output enable (1 = pad is an input)
//   2 IN       RO    synchronised pad value
//   3 RISE_EN  RW    per-bit rising-edge interrupt enable
//   4 FALL_EN  RW    per-bit falling-edge interrupt enable
//   5 STATUS   RW1C  sticky edge-event flags
//   6 ID       RO    constant 0x4750494F ("GPIO")
//   7 -        reads 0, writes ignored
//
// Ports:
//   clk                  single clock, rising edge
//   reset                asynchronous active-low reset
//   io_bus_CYC/STB/WE    Wishbone cycle, strobe, write enable
//   io_bus_SEL[3:0]      byte-lane selects for writes
//   io_bus_ADR[31:0]     address (only [4:2] decoded)
//   io_bus_DAT_MOSI      write data
//   io_bus_ACK           one-cycle acknowledge
//   io_bus_DAT_MISO      read data, valid with ACK, zero otherwise
//   io_gpio_read         raw asynchronous pad inputs
//   io_gpio_write        pad output data (flop output)
//   io_gpio_writeEnable  pad output enable, active low (flop output)
//   io_irq[2:0]          [0] = any STATUS bit set, [2:1] = 0
//
// Bus handshake: a request is present whenever CYC=1 and STB=1. The slave
// accepts it on a rising edge where ACK is currently 0; on that same edge the
// write (if WE=1) is committed, ACK rises and DAT_MISO is loaded. ACK is then
// forced low on the next edge, so a request held continuously completes once
// every two cycles. Requests with CYC=0 or STB=0 are ignored entirely.
// -----------------------------------------------------------------------------
module wb_gpio_ctrl #(
    parameter int GPIO_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  io_bus_CYC,
    input  logic                  io_bus_STB,
    input  logic                  io_bus_WE,
    input  logic [3:0]            io_bus_SEL,
    input  logic [31:0]           io_bus_ADR,
    input  logic [31:0]           io_bus_DAT_MOSI,
    output logic                  io_bus_ACK,
    output logic [31:0]           io_bus_DAT_MISO,
    input  logic [GPIO_WIDTH-1:0] io_gpio_read,
    output logic [GPIO_WIDTH-1:0] io_gpio_write,
    output logic [GPIO_WIDTH-1:0] io_gpio_writeEnable,
    output logic [2:0]            io_irq
);

    localparam logic [31:0] ID_VALUE = 32'h4750_494F;

    localparam logic [2:0] IDX_OUT     = 3'd0;
    localparam logic [2:0] IDX_OEB     = 3'd1;
    localparam logic [2:0] IDX_IN      = 3'd2;
    localparam logic [2:0] IDX_RISE_EN = 3'd3;
    localparam logic [2:0] IDX_FALL_EN = 3'd4;
    localparam logic [2:0] IDX_STATUS  = 3'd5;
    localparam logic [2:0] IDX_ID      = 3'd6;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [GPIO_WIDTH-1:0] out_reg;
    logic [GPIO_WIDTH-1:0] oeb_reg;
    logic [GPIO_WIDTH-1:0] rise_en_reg;
    logic [GPIO_WIDTH-1:0] fall_en_reg;
    logic [GPIO_WIDTH-1:0] status_reg;

    // Pad input synchroniser (two stages) plus one history stage for edges.
    logic [GPIO_WIDTH-1:0] sync_1;
    logic [GPIO_WIDTH-1:0] sync_2;
    logic [GPIO_WIDTH-1:0] prev;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       access;
    logic       wr_access;
    logic [2:0] reg_idx;

    assign access    = io_bus_CYC & io_bus_STB & ~io_bus_ACK;
    assign wr_access = access & io_bus_WE;
    assign reg_idx   = io_bus_ADR[4:2];

    // Address bits outside [4:2] are deliberately ignored; write-data bits
    // above GPIO_WIDTH have no storage behind them.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{io_bus_ADR[31:5], io_bus_ADR[1:0], io_bus_DAT_MOSI};

    // Expand the byte selects into a bit mask, then truncate to the GPIO width
    // so bits above GPIO_WIDTH can never be written.
    logic [31:0]           byte_mask;
    logic [GPIO_WIDTH-1:0] wr_mask;
    logic [GPIO_WIDTH-1:0] wr_data;

    always_comb begin
        byte_mask = '0;
        for (int b = 0; b < 4; b++) begin
            byte_mask[8*b +: 8] = {8{io_bus_SEL[b]}};
        end
    end

    assign wr_mask = byte_mask[GPIO_WIDTH-1:0];
    assign wr_data = io_bus_DAT_MOSI[GPIO_WIDTH-1:0];

    function automatic logic [GPIO_WIDTH-1:0] merge_bytes(
        input logic [GPIO_WIDTH-1:0] old_val,
        input logic [GPIO_WIDTH-1:0] new_val,
        input logic [GPIO_WIDTH-1:0] mask
    );
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    logic wr_out;
    logic wr_oeb;
    logic wr_rise_en;
    logic wr_fall_en;
    logic wr_status;

    assign wr_out     = wr_access && (reg_idx == IDX_OUT);
    assign wr_oeb     = wr_access && (reg_idx == IDX_OEB);
    assign wr_rise_en = wr_access && (reg_idx == IDX_RISE_EN);
    assign wr_fall_en = wr_access && (reg_idx == IDX_FALL_EN);
    assign wr_status  = wr_access && (reg_idx == IDX_STATUS);

    // ------------------------------------------------------------------
    // Read multiplexer (zero-extended to 32 bits)
    // ------------------------------------------------------------------
    logic [31:0] read_data;

    always_comb begin
        read_data = '0;
        case (reg_idx)
            IDX_OUT:     read_data[GPIO_WIDTH-1:0] = out_reg;
            IDX_OEB:     read_data[GPIO_WIDTH-1:0] = oeb_reg;
            IDX_IN:      read_data[GPIO_WIDTH-1:0] = sync_2;
            IDX_RISE_EN: read_data[GPIO_WIDTH-1:0] = rise_en_reg;
            IDX_FALL_EN: read_data[GPIO_WIDTH-1:0] = fall_en_reg;
            IDX_STATUS:  read_data[GPIO_WIDTH-1:0] = status_reg;
            IDX_ID:      read_data = ID_VALUE;
            default:     read_data = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Acknowledge and read data
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_bus_ACK      <= 1'b0;
            io_bus_DAT_MISO <= '0;
        end else if (access) begin
            io_bus_ACK      <= 1'b1;
            io_bus_DAT_MISO <= read_data;
        end else begin
            io_bus_ACK      <= 1'b0;
            io_bus_DAT_MISO <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_reg     <= '0;
            oeb_reg     <= '1;
            rise_en_reg <= '0;
            fall_en_reg <= '0;
        end else begin
            if (wr_out)     out_reg     <= merge_bytes(out_reg, wr_data, wr_mask);
            if (wr_oeb)     oeb_reg     <= merge_bytes(oeb_reg, wr_data, wr_mask);
            if (wr_rise_en) rise_en_reg <= merge_bytes(rise_en_reg, wr_data, wr_mask);
            if (wr_fall_en) fall_en_reg <= merge_bytes(fall_en_reg, wr_data, wr_mask);
        end
    end

    // ------------------------------------------------------------------
    // Pad input synchroniser and edge history
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
            prev   <= '0;
        end else begin
            sync_1 <= io_gpio_read;
            sync_2 <= sync_1;
            prev   <= sync_2;
        end
    end

    // ------------------------------------------------------------------
    // Edge detection and sticky status
    // ------------------------------------------------------------------
    logic [GPIO_WIDTH-1:0] rise;
    logic [GPIO_WIDTH-1:0] fall;
    logic [GPIO_WIDTH-1:0] edge_event;
    logic [GPIO_WIDTH-1:0] status_clr;

    assign rise       = sync_2 & ~prev;
    assign fall       = ~sync_2 & prev;
    // Enables are sampled at the moment the edge is seen; an edge that
    // arrives while its enable is 0 is lost for good.
    assign edge_event = (rise & rise_en_reg) | (fall & fall_en_reg);
    assign status_clr = wr_status ? (wr_data & wr_mask) : '0;

    // Clear is applied first and the new event OR-ed afterwards, so a
    // simultaneous event wins over a W1C of the same bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_reg <= '0;
        end else begin
            status_reg <= (status_reg & ~status_clr) | edge_event;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: pad controls come straight from flops
    // ------------------------------------------------------------------
    assign io_gpio_write       = out_reg;
    assign io_gpio_writeEnable = oeb_reg;
    assign io_irq              = {2'b00, |status_reg};

endmodule

// File: doc/wb_gpio_ctrl.md
WB_GPIO_CTRL -- requirements
Module: wb_gpio_ctrl

Interface
REQ-001 SHALL have parameter GPIO_WIDTH, default 32, giving the number of GPIO bits controlled, range 1..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-low reset: 0 = reset.
REQ-004 SHALL have ports io_bus_CYC, io_bus_STB, io_bus_WE, inputs, 1 each: Wishbone classic cycle, strobe and write-enable.
REQ-005 SHALL have port io_bus_SEL, input, 4: Wishbone byte-lane selects.
REQ-006 SHALL have ports io_bus_ADR and io_bus_DAT_MOSI, inputs, 32 each: address and write data.
REQ-007 SHALL have ports io_bus_ACK, output, 1, and io_bus_DAT_MISO, output, 32: acknowledge and read data.
REQ-008 SHALL have port io_gpio_read, input, GPIO_WIDTH: raw asynchronous pad inputs.
REQ-009 SHALL have ports io_gpio_write and io_gpio_writeEnable, outputs, GPIO_WIDTH: pad output data and active-low output enable (1 = pad is an input).
REQ-010 SHALL have port io_irq, output, 3: interrupt lines.

Function
REQ-011 SHALL decode register index from io_bus_ADR[4:2] and ignore all other address bits.
REQ-012 SHALL implement: 0 OUT (RW), 1 OEB (RW), 2 IN (RO), 3 RISE_EN (RW), 4 FALL_EN (RW), 5 STATUS (RW1C), 6 ID (RO, 0x4750494F), 7 reserved (reads 0, writes ignored).
REQ-013 SHALL register io_bus_ACK high for exactly one cycle, one cycle after clk samples CYC=1, STB=1, ACK=0; ACK deasserts the following cycle, so back-to-back accesses complete every second cycle.
REQ-014 SHALL commit a write on the same clk edge that raises ACK, updating only bytes whose SEL bit is 1.
REQ-015 SHALL drive io_bus_DAT_MISO with the addressed register, registered together with ACK, and 0 in every cycle where ACK=0.
REQ-016 SHALL zero-extend registers to 32 bits; bits at or above GPIO_WIDTH read 0 and ignore writes.
REQ-017 SHALL drive io_gpio_write from OUT and io_gpio_writeEnable from OEB directly from flops, with no combinational path from the bus.
REQ-018 SHALL synchronise io_gpio_read through two flops; IN returns the second-stage value.
REQ-019 SHALL keep a third flop stage (prev); rise = sync & ~prev, fall = ~sync & prev.
REQ-020 SHALL set STATUS[i] when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]); bits stay set until cleared.
REQ-021 SHALL clear STATUS[i] on a STATUS write with a 1 in bit i (byte enabled); writing 0 has no effect.
REQ-022 SHALL give set priority when a W1C clear and a new event hit the same bit in the same cycle: the bit stays 1.
REQ-023 SHALL not set STATUS for edges that occurred while the enable bit was 0; enabling later does not recall them.
REQ-024 SHALL drive io_irq[0] = OR of STATUS bits from flops, and io_irq[2:1] = 0.
REQ-025 SHALL give latency: pad change at edge N is visible in IN after edge N+2 and in STATUS/io_irq[0] after edge N+3.
REQ-026 SHALL ignore accesses with CYC=0 or STB=0, and SHALL not ACK or change state for them.

Reset
REQ-027 SHALL, on reset=0, asynchronously set: OUT=0, OEB=all ones, RISE_EN=0, FALL_EN=0, STATUS=0, sync/prev flops=0, ACK=0, DAT_MISO=0, io_irq=0.
REQ-028 SHALL, on reset asserted mid-access, drop ACK immediately and discard the pending write; after release, an access still held on the bus completes normally.

Verification
REQ-029 SHALL cover: after reset, read reg 6 -> 0x4750494F; read reg 1 -> 0xFFFFFFFF; io_gpio_writeEnable all ones.
REQ-030 SHALL cover: write OUT=0x12345678 with SEL=0b0101 over OUT=0 -> OUT reads 0x00340078; io_gpio_write matches the cycle after ACK.
REQ-031 SHALL cover: RISE_EN=0x1, drive io_gpio_read[0] 0->1 -> STATUS=0x1 and io_irq=3'b001 three cycles later; FALL event with FALL_EN=0 -> no change.
REQ-032 SHALL cover: STATUS=0x3, write 0x1 to STATUS -> STATUS=0x2; a W1C of bit 1 in the same cycle as a new bit-1 rise -> STATUS bit 1 stays 1.
REQ-033 SHALL cover: CYC=STB=1 held continuously for 4 reads -> ACK pattern 0,1,0,1,0,1,0,1 and DAT_MISO=0 on non-ACK cycles; reset pulsed during a write -> register unchanged.
